pulse_event_arbiter: RTL

Collects rising-edge events from N multi-cycle level request lines and hands them one at a time to a single shared resource (e.g. the SPI transmit engine) through a valid/ready grant handshake. Each requester gets exactly one grant per low-to-high transition of its line, however long the line stays high. Requesters are served in round-robin order. The block sits between the synchronised request sources (buttons, GPIO, timer strobes) and the shared SPI datapath.

---
 rtl/pulse_arb_pkg.sv | 14 +
 rtl/edge_capture.sv | 33 +++
 rtl/pulse_event_arbiter.sv | 98 +++++++++
 3 files changed

// File: rtl/pulse_arb_pkg.sv
// Shared types and helpers for the pulse event arbiter: FSM states,
// the default channel count and the modulo-N round-robin step.
package pulse_arb_pkg;

  typedef enum logic {IDLE, OFFER} state_t;

  localparam int DEFAULT_N = 4;

  // Wraps at n-1 -> 0, never at a power of two.
  function automatic int rr_next(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/edge_capture.sv
// Per-channel rising-edge detector with a one-deep pending flag;
// an edge that finds the flag already set and not being accepted is dropped.
module edge_capture (
  input  logic clk,
  input  logic rst_l,
  input  logic lvl,
  input  logic accept,
  output logic pending,
  output logic overflow
);

  logic prev_lvl;
  logic evt;

  assign evt = lvl & ~prev_lvl;

  // An edge coinciding with acceptance re-arms pending instead of overflowing.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      prev_lvl <= 1'b0;
      pending  <= 1'b0;
      overflow <= 1'b0;
    end else begin
      prev_lvl <= lvl;
      overflow <= evt & pending & ~accept;
      if (evt)
        pending <= 1'b1;
      else if (accept)
        pending <= 1'b0;
    end
  end

endmodule

// File: rtl/pulse_event_arbiter.sv
// Turns rising edges on N level request lines into single valid/ready
// grants for one shared resource, served in round-robin order.
module pulse_event_arbiter
  import pulse_arb_pkg::*;
#(
  parameter int N    = DEFAULT_N,
  parameter int ID_W = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst_l,
  input  logic [N-1:0]    req_lvl,
  input  logic [N-1:0]    en,
  output logic            grant_valid,
  output logic [ID_W-1:0] grant_id,
  input  logic            grant_ready,
  output logic [N-1:0]    pending,
  output logic [N-1:0]    overflow,
  output logic            busy
);

  state_t          state, state_next;
  logic [ID_W-1:0] grant_id_next;
  logic [ID_W-1:0] last_grant, last_grant_next;
  logic [N-1:0]    accept;
  logic [N-1:0]    cand;
  logic [ID_W-1:0] sel;
  logic            found;
  int              start;

  for (genvar g = 0; g < N; g++) begin : g_chan
    assign accept[g] = grant_valid & grant_ready & (grant_id == ID_W'(g));

    edge_capture u_cap (
      .clk      (clk),
      .rst_l    (rst_l),
      .lvl      (req_lvl[g]),
      .accept   (accept[g]),
      .pending  (pending[g]),
      .overflow (overflow[g])
    );
  end

  assign cand = pending & en;

  // Lowest candidate at or above start wins; otherwise wrap to the lowest overall.
  always_comb begin
    start = rr_next(int'(last_grant), N);
    found = 1'b0;
    sel   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (cand[i]) begin
        found = 1'b1;
        sel   = ID_W'(i);
      end
    end
    for (int i = N - 1; i >= 0; i--) begin
      if (cand[i] && i >= start)
        sel = ID_W'(i);
    end
  end

  always_comb begin
    state_next      = state;
    grant_id_next   = grant_id;
    last_grant_next = last_grant;
    case (state)
      IDLE: begin
        if (found) begin
          grant_id_next = sel;
          state_next    = OFFER;
        end
      end
      OFFER: begin
        if (grant_ready) begin
          last_grant_next = grant_id;
          state_next      = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state      <= IDLE;
      grant_id   <= '0;
      last_grant <= ID_W'(N - 1);
    end else begin
      state      <= state_next;
      grant_id   <= grant_id_next;
      last_grant <= last_grant_next;
    end
  end

  assign grant_valid = (state == OFFER);
  assign busy        = (state == OFFER);

endmodule
